// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the word-copy DMA engine.
// The state enum, config register offsets and CTRL/STATUS bit positions live here.
package bus_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RGAP,
    ST_WRITE,
    ST_WGAP
  } state_t;

  localparam logic [3:0] OFF_SRC   = 4'h0;
  localparam logic [3:0] OFF_DST   = 4'h4;
  localparam logic [3:0] OFF_COUNT = 4'h8;
  localparam logic [3:0] OFF_CTRL  = 4'hC;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

endpackage

// File: rtl/bus_dma.sv
// Word-copy DMA: a register-mapped config port plus a bus initiator that moves
// COUNT words from SRC to DST as read/gap/write/gap sequences.
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_rw,
  input  logic [3:0]            i_address,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_ready,
  output logic                  o_bus_request,
  output logic                  o_bus_rw,
  output logic [ADDR_WIDTH-1:0] o_bus_address,
  output logic [31:0]           o_bus_wdata,
  input  logic                  i_bus_ready,
  input  logic [31:0]           i_bus_rdata,
  output logic                  o_busy
);

  state_t                 state_q;
  logic                   req_q, rw_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [31:0]            wdata_q;

  logic [ADDR_WIDTH-1:0]  src_q, src_d, dst_q, dst_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_q, done_d;

  logic                   busy, cfg_wr, ctrl_wr, start_fire, word_done, job_end;
  logic [1:0]             reg_sel;
  logic                   unused_addr_bits;

  assign reg_sel          = i_address[3:2];
  assign unused_addr_bits = ^i_address[1:0];
  assign busy             = (state_q != ST_IDLE);
  assign cfg_wr           = i_enable & i_rw;
  assign ctrl_wr          = cfg_wr && (reg_sel == OFF_CTRL[3:2]);
  assign start_fire       = ctrl_wr && i_wdata[CTRL_START] && !busy;
  assign word_done        = (state_q == ST_WRITE) && i_bus_ready;
  assign job_end          = (state_q == ST_WGAP) && (count_q == '0);

  // Register file: config writes only land while idle; during a job the
  // address/count registers act as live counters stepped per copied word.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    done_d  = done_q;
    if (cfg_wr && !busy) begin
      case (reg_sel)
        OFF_SRC[3:2]:   src_d   = ADDR_WIDTH'(i_wdata & 32'hFFFF_FFFC);
        OFF_DST[3:2]:   dst_d   = ADDR_WIDTH'(i_wdata & 32'hFFFF_FFFC);
        OFF_COUNT[3:2]: count_d = COUNT_WIDTH'(i_wdata);
        default: ;
      endcase
    end
    if (ctrl_wr && i_wdata[CTRL_CLEAR]) done_d = 1'b0;
    // A zero-length job completes on the start write itself.
    if (start_fire) done_d = (count_q == '0);
    if (word_done) begin
      src_d   = src_q + ADDR_WIDTH'(4);
      dst_d   = dst_q + ADDR_WIDTH'(4);
      count_d = count_q - COUNT_WIDTH'(1);
    end
    if (job_end) done_d = 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Bus sequencer; request/rw/address are registered so they stay put while
  // the responder stalls.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_fire && count_q != '0) begin
            state_q <= ST_READ;
            req_q   <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= src_q;
          end
        end
        ST_READ: begin
          if (i_bus_ready) begin
            wdata_q <= i_bus_rdata;
            req_q   <= 1'b0;
            state_q <= ST_RGAP;
          end
        end
        ST_RGAP: begin
          req_q   <= 1'b1;
          rw_q    <= 1'b1;
          addr_q  <= dst_q;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (i_bus_ready) begin
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            state_q <= ST_WGAP;
          end
        end
        ST_WGAP: begin
          // count_q and src_q already reflect the word just written.
          if (count_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            req_q   <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= src_q;
            state_q <= ST_READ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          rw_q    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    case (reg_sel)
      OFF_SRC[3:2]:   o_rdata = 32'(src_q);
      OFF_DST[3:2]:   o_rdata = 32'(dst_q);
      OFF_COUNT[3:2]: o_rdata = 32'(count_q);
      default: begin
        o_rdata[STAT_BUSY] = busy;
        o_rdata[STAT_DONE] = done_q;
      end
    endcase
  end

  assign o_ready       = i_enable;
  assign o_bus_request = req_q;
  assign o_bus_rw      = rw_q;
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_busy        = busy;

endmodule

// File: tb/tb_bus_dma.sv
// Randomized bench for bus_dma: a stalling memory responder plus a sequential
// copy model that predicts every bus access, job length and register readback.
module tb_bus_dma;

  logic        clk, rst_n;
  logic        i_enable, i_rw;
  logic [3:0]  i_address;
  logic [31:0] i_wdata, o_rdata;
  logic        o_ready, o_bus_request, o_bus_rw, o_busy;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  logic        override;
  logic        tog_ready, resp_ready;
  logic [31:0] tog_rdata, resp_rdata;
  assign i_bus_ready = override ? tog_ready : resp_ready;
  assign i_bus_rdata = override ? tog_rdata : resp_rdata;

  bus_dma #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_enable(i_enable), .i_rw(i_rw), .i_address(i_address), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_ready(o_ready),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
    .o_bus_wdata(o_bus_wdata), .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .o_busy(o_busy)
  );

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 0;
  int          req_seen = 0;
  int          stab_err = 0;
  logic [31:0] mem [logic [31:0]];
  acc_t        acc_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers each request after `lat` stall cycles and
  // watches that the request is held steady while it stalls.
  initial begin
    bit          holding;
    int          wait_cnt;
    acc_t        h;
    holding    = 0;
    wait_cnt   = 0;
    h          = '0;
    resp_ready = 1'b0;
    resp_rdata = '0;
    forever begin
      @(negedge clk);
      resp_ready = 1'b0;
      if (!rst_n || !o_bus_request) begin
        if (rst_n && holding) stab_err++;
        holding  = 0;
        wait_cnt = 0;
      end else begin
        if (!holding) begin
          holding  = 1;
          wait_cnt = 0;
          h.rw     = o_bus_rw;
          h.addr   = o_bus_address;
          h.data   = o_bus_wdata;
          req_seen++;
        end else if (o_bus_rw !== h.rw || o_bus_address !== h.addr ||
                     (h.rw && o_bus_wdata !== h.data)) begin
          stab_err++;
        end
        if (wait_cnt >= lat) begin
          resp_ready = 1'b1;
          if (h.rw) begin
            mem[h.addr] = h.data;
          end else begin
            resp_rdata = mem.exists(h.addr) ? mem[h.addr] : 32'h0;
            h.data     = resp_rdata;
          end
          acc_q.push_back(h);
          holding = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    i_enable = 1'b1; i_rw = 1'b1; i_address = a; i_wdata = d;
    @(posedge clk);
    #1;
    i_enable = 1'b0; i_rw = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    i_enable = 1'b1; i_rw = 1'b0; i_address = a;
    #1;
    d = o_rdata;
    chk("cfg_ready", {63'd0, o_ready}, 64'd1);
    i_enable = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] src_raw, input logic [31:0] dst_raw, input int n,
                         input int l, input bit poke, input logic [31:0] ctrl);
    logic [31:0] s, d, a, v, r;
    logic [31:0] ref_mem [logic [31:0]];
    acc_t        exp_q[$];
    acc_t        e;
    int          el, req0, start_cyc;
    s   = src_raw & 32'hFFFF_FFFC;
    d   = dst_raw & 32'hFFFF_FFFC;
    lat = l;
    for (int i = 0; i < n; i++) mem[s + 32'(4 * i)] = $urandom;
    ref_mem = mem;
    // Sequential word copy: later reads see earlier writes when ranges overlap.
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      v = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
      e.rw = 1'b0; e.addr = a; e.data = v;
      exp_q.push_back(e);
      a = d + 32'(4 * i);
      ref_mem[a] = v;
      e.rw = 1'b1; e.addr = a; e.data = v;
      exp_q.push_back(e);
    end
    cfg_write(4'h0, src_raw);
    cfg_write(4'h4, dst_raw);
    cfg_write(4'h8, 32'(n));
    acc_q.delete();
    stab_err = 0;
    req0 = req_seen;
    cfg_write(4'hC, ctrl);
    start_cyc = cyc;
    if (n > 0) begin
      cfg_read(4'hC, r);
      chk("status_running", {32'd0, r}, 64'd1);
    end
    if (poke) begin
      repeat (2) @(negedge clk);
      cfg_write(4'hC, 32'h1);
      cfg_write(4'h0, 32'h1234_5678);
      cfg_write(4'h4, 32'h0000_0040);
    end
    el = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!o_busy) begin
        el = cyc - start_cyc;
        break;
      end
    end
    chk("job_cycles", 64'(el), 64'(4 * n + 2 * n * l));
    chk("bus_requests", 64'(req_seen - req0), 64'(2 * n));
    chk("held_stable", 64'(stab_err), 64'd0);
    chk("access_count", 64'(acc_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
      chk("access_rw_addr", {31'd0, acc_q[k].rw, acc_q[k].addr}, {31'd0, exp_q[k].rw, exp_q[k].addr});
      chk("access_data", {32'd0, acc_q[k].data}, {32'd0, exp_q[k].data});
    end
    for (int i = 0; i < n; i++) begin
      a = d + 32'(4 * i);
      chk("dest_word", {32'd0, mem.exists(a) ? mem[a] : 32'hx}, {32'd0, ref_mem[a]});
    end
    cfg_read(4'h0, r); chk("src_final", {32'd0, r}, {32'd0, s + 32'(4 * n)});
    cfg_read(4'h4, r); chk("dst_final", {32'd0, r}, {32'd0, d + 32'(4 * n)});
    cfg_read(4'h8, r); chk("count_final", {32'd0, r}, 64'd0);
    cfg_read(4'hC, r); chk("status_done", {32'd0, r}, 64'd2);
    $display("job src=0x%08h dst=0x%08h n=%0d lat=%0d poke=%0d cycles=%0d", s, d, n, l, poke, el);
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; override = 1'b1;
    i_enable = 1'b0; i_rw = 1'b0; i_address = '0; i_wdata = '0;
    tog_ready = 1'b0; tog_rdata = '0;

    // Reset with every input toggling.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i_enable = 1'($urandom); i_rw = 1'($urandom); i_address = 4'($urandom);
      i_wdata = $urandom; tog_ready = 1'($urandom); tog_rdata = $urandom;
      #1;
      chk("rst_ready_follows", {63'd0, o_ready}, {63'd0, i_enable});
    end
    chk("rst_request", {63'd0, o_bus_request}, 64'd0);
    chk("rst_rw", {63'd0, o_bus_rw}, 64'd0);
    chk("rst_address", {32'd0, o_bus_address}, 64'd0);
    chk("rst_wdata", {32'd0, o_bus_wdata}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    @(negedge clk);
    i_enable = 1'b0; i_rw = 1'b0; override = 1'b0;
    rst_n = 1'b1;
    cfg_read(4'hC, r); chk("rst_status", {32'd0, r}, 64'd0);
    cfg_read(4'h0, r); chk("rst_src", {32'd0, r}, 64'd0);
    cfg_read(4'h8, r); chk("rst_count", {32'd0, r}, 64'd0);

    run_job(32'h0001_0000, 32'h0001_0100, 3, 0, 1'b0, 32'h1);
    run_job(32'h0001_0000, 32'h0001_0100, 3, 2, 1'b0, 32'h1);

    // Zero-length job; start and clear together, start wins.
    run_job(32'h0000_2000, 32'h0000_3000, 0, 0, 1'b0, 32'h3);
    cfg_write(4'hC, 32'h2);
    cfg_read(4'hC, r); chk("done_cleared", {32'd0, r}, 64'd0);

    run_job(32'h0002_0000, 32'h0002_0800, 4, 1, 1'b1, 32'h1);
    run_job(32'hFFFF_FFFC, 32'h0000_5000, 2, 0, 1'b0, 32'h1);

    for (int j = 0; j < 6; j++) begin
      run_job(32'h0000_4000 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3),
              32'h0000_4000 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3),
              $urandom_range(1, 5), $urandom_range(0, 3), 1'($urandom), 32'($urandom_range(1, 3)) | 32'h1);
    end

    // Reset while READ is stalled on ready.
    lat = 40;
    cfg_write(4'h0, 32'h0000_6000);
    cfg_write(4'h4, 32'h0000_7000);
    cfg_write(4'h8, 32'd2);
    cfg_write(4'hC, 32'h1);
    repeat (3) @(negedge clk);
    chk("req_before_reset", {63'd0, o_bus_request}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("req_async_drop", {63'd0, o_bus_request}, 64'd0);
    chk("busy_async_drop", {63'd0, o_busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    cfg_read(4'hC, r); chk("status_after_reset", {32'd0, r}, 64'd0);
    cfg_read(4'h0, r); chk("src_after_reset", {32'd0, r}, 64'd0);
    repeat (4) @(negedge clk);
    chk("idle_after_reset", {63'd0, o_bus_request}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
